// File: rtl/if_prefetch.sv
// Instruction-fetch front end: issues sequential PCs under a credit limit and buffers
// in-order {pc, inst} responses in a small FIFO; redirects flush and squash in-flight fetches.
module if_prefetch #(
    parameter int                ADDR_W   = 64,
    parameter int                INST_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_resp_valid,
    input  logic [INST_W-1:0] imem_resp_inst,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_pc,
    output logic [INST_W-1:0] out_inst
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic              run_reg;
    logic [ADDR_W-1:0] fetch_pc_reg;
    logic [ADDR_W-1:0] resp_pc_reg;
    logic [CNT_W-1:0]  inflight_reg;
    logic [CNT_W-1:0]  drop_reg;
    logic [CNT_W-1:0]  count_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [PTR_W-1:0]  wr_ptr_reg;

    logic [ADDR_W-1:0] pc_mem   [DEPTH];
    logic [INST_W-1:0] inst_mem [DEPTH];

    logic [CNT_W:0]    occupancy;
    logic              fire;
    logic              pop;
    logic              push;
    logic [CNT_W-1:0]  inflight_next;

    // Buffered plus outstanding entries never exceed DEPTH, so a response always has a slot.
    assign occupancy      = {1'b0, count_reg} + {1'b0, inflight_reg};
    assign imem_req_valid = run_reg && (occupancy < (CNT_W+1)'(DEPTH));
    assign imem_req_addr  = fetch_pc_reg;

    assign fire          = imem_req_valid && imem_req_ready;
    assign pop           = out_valid && out_ready;
    assign push          = imem_resp_valid && !redirect_valid && (drop_reg == '0);
    assign inflight_next = inflight_reg + CNT_W'(fire) - CNT_W'(imem_resp_valid);

    assign out_valid = (count_reg != '0);
    assign out_pc    = out_valid ? pc_mem[rd_ptr_reg]   : '0;
    assign out_inst  = out_valid ? inst_mem[rd_ptr_reg] : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_reg      <= 1'b0;
            fetch_pc_reg <= RESET_PC;
            resp_pc_reg  <= RESET_PC;
            inflight_reg <= '0;
            drop_reg     <= '0;
            count_reg    <= '0;
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
        end else begin
            run_reg      <= 1'b1;
            inflight_reg <= inflight_next;
            if (redirect_valid) begin
                // Everything still outstanding after this edge belongs to the old path.
                count_reg    <= '0;
                rd_ptr_reg   <= '0;
                wr_ptr_reg   <= '0;
                fetch_pc_reg <= redirect_pc;
                resp_pc_reg  <= redirect_pc;
                drop_reg     <= inflight_next;
            end else begin
                if (fire) begin
                    fetch_pc_reg <= fetch_pc_reg + ADDR_W'(4);
                end
                if (imem_resp_valid && (drop_reg != '0)) begin
                    drop_reg <= drop_reg - CNT_W'(1);
                end
                if (push) begin
                    resp_pc_reg <= resp_pc_reg + ADDR_W'(4);
                    wr_ptr_reg  <= wr_ptr_reg + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
                end
                count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_reg]   <= resp_pc_reg;
            inst_mem[wr_ptr_reg] <= imem_resp_inst;
        end
    end

endmodule

// File: tb/tb_if_prefetch.sv
// Randomized and directed bench for if_prefetch: an in-order latency memory feeds the DUT and a
// queue-based model (each in-flight request tagged stale/live) predicts every output each cycle.
module tb_if_prefetch;

    localparam int          DEPTH    = 4;
    localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_inst = '0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_pc;
    logic [31:0] out_inst;

    if_prefetch #(.ADDR_W(64), .INST_W(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_inst (imem_resp_inst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_inst       (out_inst)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: decode-visible buffer plus in-flight requests tagged stale or live.
    bit          m_run;
    logic [63:0] m_fetch;
    logic [63:0] mo_pc[$];
    logic [31:0] mo_inst[$];
    logic [63:0] mp_addr[$];
    bit          mp_stale[$];

    // Memory: in-order queue of addresses with the earliest cycle each may respond.
    logic [63:0] mq_addr[$];
    int          mq_due[$];
    int          cyc = 0;
    int          fires = 0;

    int          k_ready, k_resp, k_oready, k_lat_min, k_lat_max, k_redir;
    bit          f_redir = 1'b0;
    logic [63:0] f_redir_pc = '0;

    function automatic logic [31:0] inst_of(input logic [63:0] a);
        return (a[33:2] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h0000_0013;
    endfunction

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic cycle();
        bit          exp_rv, exp_ov, fire, pop, s;
        logic [63:0] a;
        int          lat;
        @(posedge clk);
        #1;
        cyc++;
        exp_rv = m_run && ((mo_pc.size() + mp_addr.size()) < DEPTH);
        exp_ov = (mo_pc.size() != 0);
        check64("req_valid", 64'(imem_req_valid), 64'(exp_rv));
        check64("req_addr",  imem_req_addr, m_fetch);
        check64("out_valid", 64'(out_valid), 64'(exp_ov));
        check64("out_pc",    out_pc, exp_ov ? mo_pc[0] : 64'h0);
        check64("out_inst",  64'(out_inst), exp_ov ? 64'(mo_inst[0]) : 64'h0);

        imem_req_ready = ($urandom_range(99) < k_ready);
        if (mq_addr.size() > 0 && mq_due[0] <= cyc && $urandom_range(99) < k_resp) begin
            imem_resp_valid = 1'b1;
            imem_resp_inst  = inst_of(mq_addr[0]);
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_inst  = $urandom;
        end
        out_ready = ($urandom_range(99) < k_oready);
        if (f_redir) begin
            redirect_valid = 1'b1;
            redirect_pc    = f_redir_pc;
            f_redir        = 1'b0;
        end else if ($urandom_range(99) < k_redir) begin
            redirect_valid = 1'b1;
            if ($urandom_range(3) == 0)
                redirect_pc = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(3) * 4);
            else
                redirect_pc = {$urandom, $urandom} & ~64'h3;
        end else begin
            redirect_valid = 1'b0;
            redirect_pc    = {$urandom, $urandom};
        end

        fire = exp_rv && imem_req_ready;
        pop  = exp_ov && out_ready;
        if (imem_req_valid && imem_req_ready) fires++;
        if (pop) begin
            $display("pop pc=%h inst=%h", mo_pc[0], mo_inst[0]);
            void'(mo_pc.pop_front());
            void'(mo_inst.pop_front());
        end
        if (imem_resp_valid) begin
            void'(mq_addr.pop_front());
            void'(mq_due.pop_front());
            a = mp_addr.pop_front();
            s = mp_stale.pop_front();
            if (!s && !redirect_valid) begin
                mo_pc.push_back(a);
                mo_inst.push_back(imem_resp_inst);
            end
        end
        if (fire) begin
            lat = $urandom_range(k_lat_max, k_lat_min);
            mq_addr.push_back(m_fetch);
            mq_due.push_back(cyc + lat);
            mp_addr.push_back(m_fetch);
            mp_stale.push_back(redirect_valid);
            m_fetch = m_fetch + 64'd4;
        end
        if (redirect_valid) begin
            mo_pc.delete();
            mo_inst.delete();
            foreach (mp_stale[i]) mp_stale[i] = 1'b1;
            m_fetch = redirect_pc;
        end
    endtask

    task automatic do_reset();
        #2 rst = 1'b0;
        #1;
        check64("rst_req_valid", 64'(imem_req_valid), 64'h0);
        check64("rst_req_addr",  imem_req_addr, RESET_PC);
        check64("rst_out_valid", 64'(out_valid), 64'h0);
        check64("rst_out_pc",    out_pc, 64'h0);
        check64("rst_out_inst",  64'(out_inst), 64'h0);
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        out_ready       = 1'b0;
        redirect_valid  = 1'b0;
        f_redir         = 1'b0;
        mo_pc.delete();
        mo_inst.delete();
        mp_addr.delete();
        mp_stale.delete();
        mq_addr.delete();
        mq_due.delete();
        m_fetch = RESET_PC;
        // The first edge after release enables fetching; the model is kept one edge ahead.
        m_run = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic wait_out(input string name);
        for (int i = 0; i < 20 && !out_valid; i++) cycle();
        check64(name, 64'(out_valid), 64'h1);
    endtask

    initial begin
        k_ready = 100; k_resp = 100; k_oready = 100;
        k_lat_min = 1; k_lat_max = 1; k_redir = 0;

        // Streaming with 1-cycle memory
        do_reset();
        cycle();
        check64("first_req_valid", 64'(imem_req_valid), 64'h1);
        check64("first_req_addr", imem_req_addr, 64'h0000_0000_8000_0000);
        cycle();
        check64("second_req_addr", imem_req_addr, 64'h0000_0000_8000_0004);
        cycle();
        check64("first_out_pc", out_pc, 64'h0000_0000_8000_0000);
        cycle();
        check64("second_out_pc", out_pc, 64'h0000_0000_8000_0004);
        repeat (16) cycle();
        check64("sustained_out_pc", out_pc, 64'h0000_0000_8000_0044);

        // Back-pressure: credits run out after DEPTH requests
        do_reset();
        k_oready = 0;
        fires = 0;
        repeat (12) cycle();
        check64("blocked_fires", 64'(fires), 64'd4);
        check64("blocked_req_valid", 64'(imem_req_valid), 64'h0);
        k_oready = 100;
        cycle();
        k_oready = 0;
        cycle();
        check64("credit_req_valid", 64'(imem_req_valid), 64'h1);
        cycle();
        check64("credit_used_req_valid", 64'(imem_req_valid), 64'h0);
        repeat (3) cycle();
        check64("credit_fires", 64'(fires), 64'd5);

        // Redirect with two requests in flight at 3-cycle latency
        do_reset();
        k_oready = 100; k_lat_min = 3; k_lat_max = 3;
        cycle();
        cycle();
        k_ready = 0;
        f_redir = 1'b1;
        f_redir_pc = 64'h0000_0000_8000_0100;
        cycle();
        k_ready = 100;
        cycle();
        check64("redir_req_addr", imem_req_addr, 64'h0000_0000_8000_0100);
        check64("redir_out_valid", 64'(out_valid), 64'h0);
        wait_out("redir_wait");
        check64("redir_out_pc", out_pc, 64'h0000_0000_8000_0100);
        check64("redir_out_inst", 64'(out_inst), 64'(inst_of(64'h0000_0000_8000_0100)));

        // Redirect coinciding with a request fire and a response
        k_lat_min = 1; k_lat_max = 1;
        repeat (6) cycle();
        f_redir = 1'b1;
        f_redir_pc = 64'h0000_0000_8000_0200;
        cycle();
        check64("coincide_req_valid", 64'(imem_req_valid), 64'h1);
        cycle();
        check64("coincide_out_valid", 64'(out_valid), 64'h0);
        wait_out("coincide_wait");
        check64("coincide_out_pc", out_pc, 64'h0000_0000_8000_0200);

        // Address wrap at the top of the space
        f_redir = 1'b1;
        f_redir_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        cycle();
        cycle();
        check64("wrap_req_addr0", imem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        cycle();
        check64("wrap_req_addr1", imem_req_addr, 64'h0);
        wait_out("wrap_wait");
        check64("wrap_out_pc0", out_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        cycle();
        check64("wrap_out_valid1", 64'(out_valid), 64'h1);
        check64("wrap_out_pc1", out_pc, 64'h0);

        // Reset while the buffer is full
        k_oready = 0;
        repeat (10) cycle();
        check64("full_out_valid", 64'(out_valid), 64'h1);
        do_reset();
        k_oready = 100;
        cycle();
        check64("restart_req_valid", 64'(imem_req_valid), 64'h1);
        check64("restart_req_addr", imem_req_addr, RESET_PC);

        // Randomized traffic
        for (int blk = 0; blk < 15; blk++) begin
            k_ready   = $urandom_range(100, 30);
            k_resp    = $urandom_range(100, 40);
            k_oready  = $urandom_range(100, 20);
            k_lat_min = $urandom_range(3, 1);
            k_lat_max = k_lat_min + $urandom_range(3, 0);
            k_redir   = $urandom_range(6, 0);
            if (blk == 7) do_reset();
            repeat (200) cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, got no end expected end");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/if_prefetch.md
# if_prefetch

- Parametrised instruction-fetch front end; successor to the fixed single-cycle fetch of the current core.
- Generates sequential PCs and issues them to instruction memory over a valid/ready request channel.
- Accepts in-order responses of variable latency and buffers {pc, inst} pairs in a DEPTH-entry FIFO for the decode stage.
- Supports pipeline redirects (branch/jump) that flush the buffer and squash in-flight fetches.

## Interface
- ADDR_W, 64: PC / memory address width.
- INST_W, 32: instruction width.
- DEPTH, 4: buffer entries and maximum in-flight requests; power of two, ≥2.
- RESET_PC, 64'h0000_0000_8000_0000: first fetch address after reset.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  ADDR_W  fetch address.
- imem_resp_valid  in  1  response valid; never back-pressured.
- imem_resp_inst  in  INST_W  fetched instruction.
- redirect_valid  in  1  flush and restart fetch.
- redirect_pc  in  ADDR_W  new fetch address.
- out_valid  out  1  buffered instruction available.
- out_ready  in  1  decode accepts instruction.
- out_pc  out  ADDR_W  PC of head entry.
- out_inst  out  INST_W  instruction of head entry.

## Operation
- State:
  - fetch_pc: next request address.
  - resp_pc: PC of the next non-stale response.
  - inflight: accepted requests not yet responded; width clog2(DEPTH)+1.
  - drop: stale responses still to discard; drop ≤ inflight.
  - FIFO: DEPTH entries with count, rd/wr pointers wrapping modulo DEPTH.
- Request:
  - imem_req_valid = (count + inflight < DEPTH); imem_req_addr = fetch_pc.
  - Fire = valid & ready.
  - On fire (no redirect): fetch_pc += 4, modulo 2^ADDR_W.
- Response:
  - Each imem_resp_valid decrements inflight.
  - If drop > 0: discard the response and decrement drop.
  - Otherwise write {resp_pc, inst} to the FIFO and increment resp_pc by 4.
  - The credit rule guarantees the FIFO never overflows.
- Output:
  - out_valid = count ≠ 0.
  - out_pc / out_inst = head entry when out_valid, else 0.
  - Pop on out_valid & out_ready.
- Redirect (redirect_valid=1), with priority over all other updates:
  - Any out handshake in the same cycle completes (entry consumed).
  - FIFO flushed: count=0, pointers=0.
  - fetch_pc ← redirect_pc; resp_pc ← redirect_pc.
  - drop ← inflight + fire − resp_valid: every outstanding request is stale, including one firing this cycle.
  - A response arriving in the redirect cycle is discarded.
  - A request firing in the redirect cycle uses the old fetch_pc and is stale.
- Simultaneous push and pop: count unchanged; legal when full if a pop occurs.

## Timing
- Reset (rst=0), asynchronous:
  - imem_req_valid=0, imem_req_addr=RESET_PC, out_valid=0, out_pc=0, out_inst=0.
  - inflight=0, drop=0, count=0, fetch_pc=resp_pc=RESET_PC.
- First cycle after rst rises: imem_req_valid=1, addr=RESET_PC.
- Response accepted at edge N → out_valid=1 from cycle N+1. No response→output bypass.
- With 1-cycle memory latency and out_ready held 1: one instruction per cycle sustained.
- Redirect at edge N:
  - Cycle N+1: imem_req_addr=redirect_pc, out_valid=0.
  - First redirected instruction appears one cycle after its response.
- Reset mid-operation: all state cleared immediately; pending responses after reset are the bench's responsibility (memory is also reset).
- All outputs are registered-state functions; no combinational path from inputs to outputs except imem_req_valid, which has none either (depends only on count and inflight).

## Test plan
- Reset then release with imem_req_ready=1 and 1-cycle latency, out_ready=1 → requests 0x8000_0000, 0x8000_0004, …; out_pc follows 2 cycles later, one per cycle.
- DEPTH=4, out_ready=0, memory always responds → exactly 4 requests issued, then imem_req_valid=0. Raising out_ready for 1 cycle → one pop, one new request next cycle.
- 3-cycle latency, redirect to 0x8000_0100 with 2 requests in flight → 2 responses discarded; next out_pc=0x8000_0100 with the correct inst.
- Redirect in the same cycle as a request fire and a response → both stale; drop count correct; no stale entry reaches out.
- fetch_pc=64'hFFFF_FFFF_FFFF_FFFC → next address 0; out_pc wraps identically.
- Assert rst mid-stream with FIFO full → outputs reset immediately; after release, fetch restarts at RESET_PC.
